// File: rtl/wallace_reduce16_if.sv
// Operand/result bundle between a producer and the Wallace reduction stage.
// master drives operands and enable; slave (the reducer) drives the redundant result.
interface wallace_reduce16_if #(
  parameter int WIDTH = 16
);
  logic               en;
  logic               in_valid;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic [2*WIDTH-1:0] sum_vec;
  logic [2*WIDTH-1:0] carry_vec;

  modport master (
    output en, in_valid, a, b,
    input  out_valid, sum_vec, carry_vec
  );

  modport slave (
    input  en, in_valid, a, b,
    output out_valid, sum_vec, carry_vec
  );
endinterface

// File: rtl/wallace_reduce16.sv
// Three-stage 16x16 unsigned partial-product generator and Wallace-tree reducer.
// Produces sum_vec/carry_vec whose sum mod 2^32 is a*b; a downstream CLA adds them.
module wallace_reduce16 #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  wallace_reduce16_if.slave bus
);
  localparam int OW = 2 * WIDTH;

  function automatic logic [OW-1:0] csa_sum(input logic [OW-1:0] x, y, z);
    return x ^ y ^ z;
  endfunction

  // Majority carry is shifted to its own weight; bits pushed past the top are zero
  // because every row is non-negative and the row total stays below 2^OW.
  function automatic logic [OW-1:0] csa_carry(input logic [OW-1:0] x, y, z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // Stage 1 registers
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             v1_q, v1_d;

  // Stage 2 registers
  logic [OW-1:0] rows_q [6];
  logic [OW-1:0] rows_d [6];
  logic          v2_q, v2_d;

  // Stage 3 registers
  logic [OW-1:0] sum_q, sum_d;
  logic [OW-1:0] carry_q, carry_d;
  logic          out_valid_q, out_valid_d;

  logic [OW-1:0] pp [16];
  logic [OW-1:0] l1 [11];
  logic [OW-1:0] l2 [8];
  logic [OW-1:0] l3 [6];
  logic [OW-1:0] l4 [4];
  logic [OW-1:0] l5 [3];
  logic [OW-1:0] l6 [2];

  genvar gi;

  generate
    for (gi = 0; gi < 16; gi++) begin : g_pp
      assign pp[gi] = b_q[gi] ? (OW'(a_q) << gi) : '0;
    end

    // 16 -> 11 rows
    for (gi = 0; gi < 5; gi++) begin : g_l1
      assign l1[2*gi]   = csa_sum  (pp[3*gi], pp[3*gi+1], pp[3*gi+2]);
      assign l1[2*gi+1] = csa_carry(pp[3*gi], pp[3*gi+1], pp[3*gi+2]);
    end
    assign l1[10] = pp[15];

    // 11 -> 8 rows
    for (gi = 0; gi < 3; gi++) begin : g_l2
      assign l2[2*gi]   = csa_sum  (l1[3*gi], l1[3*gi+1], l1[3*gi+2]);
      assign l2[2*gi+1] = csa_carry(l1[3*gi], l1[3*gi+1], l1[3*gi+2]);
    end
    assign l2[6] = l1[9];
    assign l2[7] = l1[10];

    // 8 -> 6 rows
    for (gi = 0; gi < 2; gi++) begin : g_l3
      assign l3[2*gi]   = csa_sum  (l2[3*gi], l2[3*gi+1], l2[3*gi+2]);
      assign l3[2*gi+1] = csa_carry(l2[3*gi], l2[3*gi+1], l2[3*gi+2]);
    end
    assign l3[4] = l2[6];
    assign l3[5] = l2[7];

    // 6 -> 4 rows, taken from the stage-2 registers
    for (gi = 0; gi < 2; gi++) begin : g_l4
      assign l4[2*gi]   = csa_sum  (rows_q[3*gi], rows_q[3*gi+1], rows_q[3*gi+2]);
      assign l4[2*gi+1] = csa_carry(rows_q[3*gi], rows_q[3*gi+1], rows_q[3*gi+2]);
    end
  endgenerate

  // 4 -> 3 -> 2 rows
  assign l5[0] = csa_sum  (l4[0], l4[1], l4[2]);
  assign l5[1] = csa_carry(l4[0], l4[1], l4[2]);
  assign l5[2] = l4[3];
  assign l6[0] = csa_sum  (l5[0], l5[1], l5[2]);
  assign l6[1] = csa_carry(l5[0], l5[1], l5[2]);

  // Every stage loads on en regardless of its valid bit; en=0 freezes the whole pipe.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    v1_d        = v1_q;
    rows_d      = rows_q;
    v2_d        = v2_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    if (bus.en) begin
      a_d         = bus.a;
      b_d         = bus.b;
      v1_d        = bus.in_valid;
      rows_d      = l3;
      v2_d        = v1_q;
      sum_d       = l6[0];
      carry_d     = l6[1];
      out_valid_d = v2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      v1_q        <= 1'b0;
      for (int i = 0; i < 6; i++) rows_q[i] <= '0;
      v2_q        <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      v1_q        <= v1_d;
      rows_q      <= rows_d;
      v2_q        <= v2_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum_vec   = sum_q;
  assign bus.carry_vec = carry_q;
endmodule
